// File: rtl/hs4_sender.sv
// Four-phase req/ack transmitter: latch din on send, hold req until synchronized ack, release, pulse done.
// Optional handshake-phase timeout abort enabled by defining HS4_TIMEOUT_EN.
`timescale 1ns/1ps

module hs4_sender #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             send,
  input  logic [WIDTH-1:0] din,
  input  logic             ack_nsyn,
  output logic             req,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

  state_t           state_q;
  logic             req_q;
  logic [WIDTH-1:0] dout_q;
  logic             done_q;
  logic             a1_q;
  logic             a2_q;
  logic             ack_s;

  // Illegal parameter combinations elaborate this empty block; it exists only as a visible marker.
  if (TIMEOUT < 4 || TIMEOUT >= (1 << CW)) begin : g_bad_cfg
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1_q <= 1'b0;
      a2_q <= 1'b0;
    end else begin
      a1_q <= ack_nsyn;
      a2_q <= a1_q;
    end
  end

  assign ack_s = a2_q;

`ifdef HS4_TIMEOUT_EN
  logic          err_q;
  logic [CW-1:0] cnt_q;
  logic          expire;

  // The abort fires on the cycle the counter would reach TIMEOUT, so req is high for exactly TIMEOUT cycles.
  assign expire = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (send && !ack_s) begin
            dout_q  <= din;
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (ack_s) begin
            req_q   <= 1'b0;
            state_q <= REL;
            cnt_q   <= '0;
          end else if (expire) begin
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        REL: begin
          if (!ack_s) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (expire) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign err = err_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      dout_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (send && !ack_s) begin
            dout_q  <= din;
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (ack_s) begin
            req_q   <= 1'b0;
            state_q <= REL;
          end
        end
        REL: begin
          if (!ack_s) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign err = 1'b0;
`endif

  // A lingering remote ack blocks new sends until it has been seen low.
  assign busy = (state_q != IDLE) | ack_s;
  assign req  = req_q;
  assign dout = dout_q;
  assign done = done_q;

endmodule

// File: tb/tb_hs4_sender.sv
// Scoreboard bench for hs4_sender: expected words queued at send time, popped on each done pulse.
`timescale 1ns/1ps

module tb_hs4_sender;

  localparam int W  = 8;
  localparam int TO = 10;
`ifdef HS4_TIMEOUT_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 0;
`endif

  logic         clk;
  logic         rst_n;
  logic         send;
  logic [W-1:0] din;
  logic         ack_nsyn;
  logic         req;
  logic [W-1:0] dout;
  logic         busy;
  logic         done;
  logic         err;

  logic         ack_man;
  logic         ack_auto = 1'b0;
  bit           resp_en  = 1'b0;

  int n_vec    = 0;
  int n_miss   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int n;
  int k;

  logic [W-1:0] exp_q[$];

  hs4_sender #(.WIDTH(W), .TIMEOUT(TO), .CW(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .send     (send),
    .din      (din),
    .ack_nsyn (ack_nsyn),
    .req      (req),
    .dout     (dout),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  assign ack_nsyn = resp_en ? ack_auto : ack_man;

  initial begin
    clk = 1'b0;
    forever #25 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic wait_done(input int target, input int bound);
    int i = 0;
    while (done_cnt < target && i < bound) begin
      @(negedge clk);
      i++;
    end
    chk("done_wait", done_cnt >= target, 1);
  endtask

  // Remote responder: follows req with a 100 ns delay in both directions.
  always begin
    logic lvl;
    @(req);
    if (resp_en) begin
      lvl = req;
      #100 ack_auto = lvl;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        done_cnt++;
        chk("done_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("done_dout", dout, exp_q.pop_front());
      end
      if (err) err_cnt++;
      if (req && exp_q.size() != 0) chk("dout_stable", dout, exp_q[0]);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    send    = 1'b1;
    din     = 8'hA5;
    ack_man = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_req",  req,  0);
      chk("rst_dout", dout, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
    end
    send  = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal transfer with a second send ignored while busy.
    resp_en = 1'b1;
    din     = 8'h3C;
    send    = 1'b1;
    exp_q.push_back(8'h3C);
    @(negedge clk);
    send = 1'b0;
    chk("nom_req",  req,  1);
    chk("nom_dout", dout, 8'h3C);
    din  = 8'hFF;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    chk("busy_flag", busy, 1);
    @(negedge clk);
    chk("busy_dout", dout, 8'h3C);
    wait_done(1, 60);
    repeat (4) @(negedge clk);
    chk("nom_done_count", done_cnt, 1);
    chk("nom_idle_busy",  busy,     0);
    chk("nom_dout_kept",  dout,     8'h3C);

    // Held send: back-to-back transfers without deasserting send.
    din  = 8'hC3;
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'hC3);
    send = 1'b1;
    k    = 0;
    for (int i = 0; i < 100 && k < 2; i++) begin
      @(negedge clk);
      if (done) k++;
    end
    send = 1'b0;
    chk("held_two_done", k, 2);
    repeat (4) @(negedge clk);
    chk("held_done_count", done_cnt, 3);
    chk("held_idle_busy",  busy,     0);

    // Stuck ack blocks sends until it has passed through the synchronizer low.
    resp_en = 1'b0;
    ack_man = 1'b1;
    repeat (3) @(negedge clk);
    chk("stuck_busy", busy, 1);
    din  = 8'h5A;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    @(negedge clk);
    chk("stuck_req",  req,  0);
    chk("stuck_dout", dout, 8'hC3);
    ack_man = 1'b0;
    n = 0;
    while (busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("stuck_release_cycles", (n >= 2 && n <= 3), 1);
    exp_q.push_back(8'h5A);
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    chk("after_stuck_req",  req,  1);
    chk("after_stuck_dout", dout, 8'h5A);
    ack_man = 1'b1;
    n = 0;
    while (req && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("after_stuck_req_fall", req, 0);
    ack_man = 1'b0;
    wait_done(4, 20);
    repeat (4) @(negedge clk);

    // Unanswered request: aborts after TO cycles if the timeout is built in, otherwise waits forever.
    din  = 8'h77;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
`ifdef HS4_TIMEOUT_EN
    n = 0;
    while (req && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("to_req_cycles", n, TO);
    repeat (3) @(negedge clk);
    chk("to_err_count",  err_cnt,  1);
    chk("to_done_count", done_cnt, 4);
    chk("to_busy",       busy,     0);
    din  = 8'h88;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
`else
    n = 0;
    repeat (1000) begin
      @(negedge clk);
      if (req) n++;
    end
    chk("hold_req_cycles", n, 1000);
    chk("hold_err_count",  err_cnt, 0);
`endif

    // Asynchronous reset between edges while in REQ.
    @(negedge clk);
    chk("arst_pre_req", req, 1);
    #10 rst_n = 1'b0;
    #1;
    chk("arst_req",  req,  0);
    chk("arst_busy", busy, 0);
    chk("arst_dout", dout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("arst_post_req",   req,      0);
    chk("arst_done_count", done_cnt, 4);
    chk("arst_err_count",  err_cnt,  EXP_ERR);
    chk("queue_drained",   exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
